abofs_sequencer: RTL and testbench



---
 rtl/abofs_sequencer.sv | 135 +++++++++++++
 tb/tb_abofs_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/abofs_sequencer.sv
// Expands one accepted block offset into a stream of alpha-offset tuples by
// stepping a per-dimension odometer (dim VDIM-1 innermost), with rdy/ack on both sides.
module abofs_sequencer #(
  parameter  int WBW     = 8,
  parameter  int VDIM    = 2,
  parameter  int N_ICFG  = 4,
  localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_bofs_rdy,
  output logic                          i_bofs_ack,
  input  logic [VDIM-1:0][WBW-1:0]      i_bofs,
  input  logic [ICFG_BW-1:0]            i_beg,
  input  logic [ICFG_BW-1:0]            i_end,
  input  logic [VDIM-1:0][WBW-1:0]      i_alpha_end,
  input  logic [VDIM-1:0][WBW-1:0]      i_alpha_step,
  output logic                          o_abofs_rdy,
  input  logic                          o_abofs_ack,
  output logic [VDIM-1:0][WBW-1:0]      o_bofs,
  output logic [VDIM-1:0][WBW-1:0]      o_aofs,
  output logic [ICFG_BW-1:0]            o_beg,
  output logic [ICFG_BW-1:0]            o_end,
  output logic                          o_islast,
  output logic                          o_bdone
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [VDIM-1:0][WBW-1:0]  bofs_q, bofs_d;
  logic [VDIM-1:0][WBW-1:0]  aofs_q, aofs_d;
  logic [VDIM-1:0][WBW-1:0]  aend_q, aend_d;
  logic [VDIM-1:0][WBW-1:0]  astep_q, astep_d;
  logic [ICFG_BW-1:0]        beg_q, beg_d;
  logic [ICFG_BW-1:0]        end_q, end_d;
  logic                      bdone_q, bdone_d;

  logic [VDIM-1:0][WBW:0]    sum;
  logic [VDIM-1:0]           wrap;
  logic [VDIM-1:0][WBW-1:0]  aofs_nxt;
  logic                      carry;
  logic                      empty;
  logic                      islast;

  // Sums carry an extra bit so offsets close to 2^WBW cannot wrap past the bound.
  always_comb begin
    sum      = '0;
    wrap     = '0;
    aofs_nxt = aofs_q;
    carry    = 1'b1;
    empty    = 1'b0;
    for (int unsigned i = 0; i < VDIM; i++) begin
      sum[i]  = {1'b0, aofs_q[i]} + {1'b0, astep_q[i]};
      wrap[i] = (sum[i] >= {1'b0, aend_q[i]});
      if (i_alpha_end[i] == '0) empty = 1'b1;
    end
    for (int unsigned i = 0; i < VDIM; i++) begin
      if (carry) begin
        aofs_nxt[VDIM-1-i] = wrap[VDIM-1-i] ? '0 : sum[VDIM-1-i][WBW-1:0];
        carry              = wrap[VDIM-1-i];
      end
    end
    islast = (state_q == S_RUN) && (&wrap);
  end

  always_comb begin
    state_d    = state_q;
    bofs_d     = bofs_q;
    aofs_d     = aofs_q;
    aend_d     = aend_q;
    astep_d    = astep_q;
    beg_d      = beg_q;
    end_d      = end_q;
    bdone_d    = 1'b0;
    i_bofs_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by reset so a request presented during reset is never acked and lost.
        i_bofs_ack = i_bofs_rdy && !i_rst;
        if (i_bofs_ack) begin
          bofs_d  = i_bofs;
          beg_d   = i_beg;
          end_d   = i_end;
          aend_d  = i_alpha_end;
          astep_d = i_alpha_step;
          aofs_d  = '0;
          if (empty) bdone_d = 1'b1;
          else       state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (o_abofs_ack) begin
          aofs_d = aofs_nxt;
          if (islast) begin
            state_d = S_IDLE;
            bdone_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      bofs_q  <= '0;
      aofs_q  <= '0;
      aend_q  <= '0;
      astep_q <= '0;
      beg_q   <= '0;
      end_q   <= '0;
      bdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bofs_q  <= bofs_d;
      aofs_q  <= aofs_d;
      aend_q  <= aend_d;
      astep_q <= astep_d;
      beg_q   <= beg_d;
      end_q   <= end_d;
      bdone_q <= bdone_d;
    end
  end

  assign o_abofs_rdy = (state_q == S_RUN);
  assign o_bofs      = bofs_q;
  assign o_aofs      = aofs_q;
  assign o_beg       = beg_q;
  assign o_end       = end_q;
  assign o_islast    = islast;
  assign o_bdone     = bdone_q;

endmodule

// File: tb/tb_abofs_sequencer.sv
// Bench for abofs_sequencer: directed and random blocks checked against a
// mixed-radix tuple model (k-th tuple derived directly from per-dim trip counts).
module tb_abofs_sequencer;
  localparam int WBW = 8;
  localparam int VDIM = 2;
  localparam int N_ICFG = 4;
  localparam int ICFG_BW = $clog2(N_ICFG + 1);

  typedef logic [VDIM-1:0][WBW-1:0] vec_t;

  logic               clk = 1'b0;
  logic               i_rst, i_bofs_rdy, i_bofs_ack, o_abofs_rdy, o_abofs_ack;
  logic               o_islast, o_bdone;
  vec_t               i_bofs, i_alpha_end, i_alpha_step, o_bofs, o_aofs;
  logic [ICFG_BW-1:0] i_beg, i_end, o_beg, o_end;

  int checks = 0;
  int failures = 0;
  logic exp_bdone = 1'b0;

  abofs_sequencer #(.WBW(WBW), .VDIM(VDIM), .N_ICFG(N_ICFG)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_bofs_rdy(i_bofs_rdy), .i_bofs_ack(i_bofs_ack),
    .i_bofs(i_bofs), .i_beg(i_beg), .i_end(i_end), .i_alpha_end(i_alpha_end),
    .i_alpha_step(i_alpha_step), .o_abofs_rdy(o_abofs_rdy), .o_abofs_ack(o_abofs_ack),
    .o_bofs(o_bofs), .o_aofs(o_aofs), .o_beg(o_beg), .o_end(o_end),
    .o_islast(o_islast), .o_bdone(o_bdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1);
    vec_t v;
    v[0] = WBW'(a0);
    v[1] = WBW'(a1);
    return v;
  endfunction

  function automatic int radix(input int e, input int s);
    return (e + s - 1) / s;
  endfunction

  function automatic int total(input vec_t e, input vec_t s);
    int t = 1;
    for (int d = 0; d < VDIM; d++) t = t * radix(int'(e[d]), int'(s[d]));
    return t;
  endfunction

  function automatic vec_t kth(input vec_t e, input vec_t s, input int k);
    vec_t v;
    int rem = k;
    for (int i = 0; i < VDIM; i++) begin
      int d = VDIM - 1 - i;
      int r = radix(int'(e[d]), int'(s[d]));
      v[d] = WBW'((rem % r) * int'(s[d]));
      rem = rem / r;
    end
    return v;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_bofs_rdy = 1'b0;
      o_abofs_ack = 1'(($urandom));
      #1;
      chk("idle_bdone", o_bdone, exp_bdone);
      chk("idle_rdy", o_abofs_rdy, 1'b0);
      chk("idle_ack", i_bofs_ack, 1'b0);
      chk("idle_islast", o_islast, 1'b0);
      @(posedge clk);
      exp_bdone = 1'b0;
    end
  endtask

  // mode 0: sink always acks; 1: ack pattern 1,0,0 repeating; 2: random ack
  task automatic run_block(input vec_t b, input logic [ICFG_BW-1:0] bg, input logic [ICFG_BW-1:0] en,
                           input vec_t e, input vec_t s, input int mode);
    int n = total(e, s);
    int k = 0;
    int cyc = 0;
    @(negedge clk);
    i_bofs_rdy = 1'b1;
    i_bofs = b; i_beg = bg; i_end = en; i_alpha_end = e; i_alpha_step = s;
    o_abofs_ack = 1'(($urandom));
    #1;
    chk("acc_ack", i_bofs_ack, 1'b1);
    chk("acc_rdy", o_abofs_rdy, 1'b0);
    chk("acc_bdone", o_bdone, exp_bdone);
    @(posedge clk);
    exp_bdone = (n == 0);
    while (k < n && cyc < 200) begin
      logic a;
      @(negedge clk);
      i_bofs_rdy = 1'(($urandom));
      i_bofs = vec_t'($urandom);
      i_beg = ICFG_BW'($urandom);
      i_alpha_end = vec_t'($urandom);
      i_alpha_step = mk($urandom_range(1, 4), $urandom_range(1, 4));
      a = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'(($urandom));
      o_abofs_ack = a;
      #1;
      chk("run_rdy", o_abofs_rdy, 1'b1);
      chk("run_ack", i_bofs_ack, 1'b0);
      chk("run_aofs", o_aofs, kth(e, s, k));
      chk("run_bofs", o_bofs, b);
      chk("run_beg", o_beg, bg);
      chk("run_end", o_end, en);
      chk("run_islast", o_islast, (k == n - 1));
      chk("run_bdone", o_bdone, 1'b0);
      @(posedge clk);
      if (a) k++;
      cyc++;
    end
    chk("tuple_count", k, n);
    if (n != 0) exp_bdone = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_bofs_rdy = 1'b0; o_abofs_ack = 1'b0;
    i_bofs = '0; i_beg = '0; i_end = '0; i_alpha_end = '0; i_alpha_step = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", o_abofs_rdy, 1'b0);
    chk("rst_ack", i_bofs_ack, 1'b0);
    chk("rst_aofs", o_aofs, 0);
    chk("rst_bofs", o_bofs, 0);
    chk("rst_bdone", o_bdone, 1'b0);
    @(negedge clk);
    i_rst = 1'b0;

    run_block(mk(5, 7), 3'd1, 3'd2, mk(2, 3), mk(1, 1), 0);
    idle_cycles(1);
    run_block(mk(1, 1), 3'd0, 3'd1, mk(1, 10), mk(1, 4), 0);
    idle_cycles(1);
    run_block(mk(2, 2), 3'd2, 3'd3, mk(1, 2), mk(1, 5), 0);
    idle_cycles(1);
    run_block(mk(5, 7), 3'd1, 3'd2, mk(2, 3), mk(1, 1), 1);
    idle_cycles(1);
    run_block(mk(9, 9), 3'd1, 3'd1, mk(0, 4), mk(1, 1), 0);
    run_block(mk(3, 4), 3'd2, 3'd4, mk(1, 1), mk(1, 1), 0);
    idle_cycles(1);
    run_block(mk(10, 11), 3'd1, 3'd2, mk(1, 2), mk(1, 1), 0);
    run_block(mk(12, 13), 3'd3, 3'd4, mk(1, 2), mk(1, 1), 0);
    idle_cycles(1);
    run_block(mk(1, 2), 3'd0, 3'd0, mk(1, 250), mk(1, 100), 0);
    run_block(mk(3, 4), 3'd1, 3'd1, mk(255, 1), mk(200, 1), 2);
    idle_cycles(1);

    // reset on the third tuple of the basic 2D block
    @(negedge clk);
    i_bofs_rdy = 1'b1; i_bofs = mk(5, 7); i_beg = 3'd1; i_end = 3'd2;
    i_alpha_end = mk(2, 3); i_alpha_step = mk(1, 1); o_abofs_ack = 1'b0;
    #1;
    chk("rr_acc", i_bofs_ack, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_bofs_rdy = 1'b0; o_abofs_ack = 1'b1;
      #1;
      chk("rr_aofs", o_aofs, kth(mk(2, 3), mk(1, 1), k));
    end
    @(negedge clk);
    i_rst = 1'b1; o_abofs_ack = 1'b0;
    #1;
    chk("rr_third", o_aofs, mk(0, 2));
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("rr_rdy", o_abofs_rdy, 1'b0);
    chk("rr_ack", i_bofs_ack, 1'b0);
    chk("rr_aofs0", o_aofs, 0);
    chk("rr_bofs0", o_bofs, 0);
    chk("rr_cfg0", {o_beg, o_end}, 0);
    chk("rr_islast", o_islast, 1'b0);
    chk("rr_bdone", o_bdone, 1'b0);
    exp_bdone = 1'b0;
    run_block(mk(6, 8), 3'd2, 3'd3, mk(2, 3), mk(1, 1), 0);
    idle_cycles(1);

    for (int i = 0; i < 20; i++) begin
      run_block(vec_t'($urandom), ICFG_BW'($urandom_range(0, N_ICFG)), ICFG_BW'($urandom_range(0, N_ICFG)),
                mk($urandom_range(0, 5), $urandom_range(0, 5)),
                mk($urandom_range(1, 4), $urandom_range(1, 4)), 2);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
